tinsel_msg_tx: RTL



---
 rtl/tinsel_noc_pkg.sv | 45 ++++
 rtl/tinsel_msg_tx.sv | 125 ++++++++++++
 2 files changed

// File: rtl/tinsel_noc_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tinsel_noc_pkg
// Brief   : Shared NoC types (NetAddr, Flit), transmitter state encoding and
//           the idle-token builder used by message senders.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef TinselBitsPerFlit
`define TinselBitsPerFlit 32
`endif

package tinsel_noc_pkg;

   localparam int FLIT_BITS = `TinselBitsPerFlit;

   // Destination address, fully supplied by the caller.
   typedef logic [15:0] NetAddr;

   typedef struct packed {
      NetAddr                 dest;
      logic [FLIT_BITS-1:0]   payload;
      logic                   notFinalFlit;
      logic                   isIdleToken;
   } Flit;

   // Transmitter output-register occupancy.
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_SEND  = 2'd1,
      TX_TOKEN = 2'd2
   } tx_state_e;

   // Idle-detection tokens are single-flit, carry no destination and are
   // never followed by another flit.
   function automatic Flit make_idle_flit(input logic [FLIT_BITS-1:0] payload);
      Flit f;
      f              = '0;
      f.payload      = payload;
      f.notFinalFlit = 1'b0;
      f.isIdleToken  = 1'b1;
      return f;
   endfunction

endpackage : tinsel_noc_pkg
`default_nettype wire

// File: rtl/tinsel_msg_tx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tinsel_msg_tx
// Brief   : Serialises one multi-flit message per handshake into a Flit
//           stream and injects single-flit idle tokens between messages.
//           All state advances on the falling clock edge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tinsel_msg_tx
   import tinsel_noc_pkg::*;
#(
   parameter int MAX_FLITS = 4,
   parameter int LEN_W     = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,          // active-high, synchronous
   input  NetAddr                         msg_dest,
   input  logic [MAX_FLITS*FLIT_BITS-1:0] msg_payload,
   input  logic [LEN_W-1:0]               msg_len,
   input  logic                           msg_valid,
   output logic                           msg_ready,
   input  logic [FLIT_BITS-1:0]           idle_payload,
   input  logic                           idle_valid,
   output logic                           idle_ready,
   output Flit                            out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [31:0]                    flit_count
);

   localparam int              IDX_W   = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FLITS);

   tx_state_e                      state_q,   state_d;
   logic [IDX_W-1:0]               idx_q,     idx_d;      // position of the flit on out_data
   logic [IDX_W-1:0]               last_q,    last_d;     // position of the final flit (L-1)
   logic [MAX_FLITS*FLIT_BITS-1:0] payload_q, payload_d;
   Flit                            out_q,     out_d;
   logic [31:0]                    count_q,   count_d;

   logic [LEN_W-1:0]               eff_len;
   logic [IDX_W-1:0]               next_idx;

   assign out_data   = out_q;
   assign out_valid  = (state_q != TX_IDLE);
   assign flit_count = count_q;

   // Next-state, output-register load and acceptance handshakes.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      last_d     = last_q;
      payload_d  = payload_q;
      out_d      = out_q;
      count_d    = count_q;
      msg_ready  = (state_q == TX_IDLE);
      idle_ready = (state_q == TX_IDLE) && !msg_valid;
      eff_len    = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
      next_idx   = idx_q + 1'b1;

      case (state_q)
         TX_IDLE: begin
            if (msg_valid) begin
               // Zero-length messages are consumed without emitting anything.
               if (eff_len != '0) begin
                  payload_d          = msg_payload;
                  last_d             = IDX_W'(eff_len - 1'b1);
                  idx_d              = '0;
                  out_d.dest         = msg_dest;
                  out_d.payload      = msg_payload[FLIT_BITS-1:0];
                  out_d.notFinalFlit = (eff_len != LEN_W'(1));
                  out_d.isIdleToken  = 1'b0;
                  state_d            = TX_SEND;
               end
            end else if (idle_valid) begin
               out_d   = make_idle_flit(idle_payload);
               state_d = TX_TOKEN;
            end
         end
         TX_SEND: begin
            if (out_ready) begin
               count_d = count_q + 32'd1;
               if (idx_q != last_q) begin
                  // Load the following flit on the same edge: no bubbles.
                  idx_d              = next_idx;
                  out_d.payload      = payload_q[next_idx*FLIT_BITS +: FLIT_BITS];
                  out_d.notFinalFlit = (next_idx != last_q);
               end else begin
                  state_d = TX_IDLE;
               end
            end
         end
         TX_TOKEN: begin
            if (out_ready) begin
               count_d = count_q + 32'd1;
               state_d = TX_IDLE;
            end
         end
         default: begin
            state_d = TX_IDLE;
         end
      endcase
   end

   // State and output register, updated on the falling edge.
   always_ff @(negedge clk) begin
      if (rst_n) begin
         state_q   <= TX_IDLE;
         idx_q     <= '0;
         last_q    <= '0;
         payload_q <= '0;
         out_q     <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         payload_q <= payload_d;
         out_q     <= out_d;
         count_q   <= count_d;
      end
   end

endmodule : tinsel_msg_tx
`default_nettype wire
